// File: rtl/dvid_timing_gen.sv
// Raster timing generator and pixel fetch/alignment stage feeding dvid; pix_* lead the dvid outputs by PIPE_LAT+1 cycles.
// Free-running with no enable or backpressure, because the downstream serializer cannot stall.
module dvid_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_LAT = 2,
  parameter int CW       = 11
) (
  input  logic          clk_pixel,
  input  logic          reset_n,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          pix_req,
  input  logic [23:0]   pix_rgb_in,
  output logic [7:0]    red_p,
  output logic [7:0]    green_p,
  output logic [7:0]    blue_p,
  output logic          blank,
  output logic          hsync,
  output logic          vsync,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  // Raw timing flags are active-high internally; polarity is applied only at the output register.
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic fs;
  } tmg_t;

  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  tmg_t          st0;
  tmg_t          dly [PIPE_LAT+1];
  tmg_t          last;

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CW'(1);
    end else begin
      hcnt <= hcnt + CW'(1);
    end
  end

  always_comb begin
    st0     = '0;
    st0.act = (hcnt < H_ACT) && (vcnt < V_ACT);
    st0.hs  = (hcnt >= HS_BEG) && (hcnt < HS_END);
    st0.vs  = (vcnt >= VS_BEG) && (vcnt < VS_END);
    st0.fs  = (hcnt == '0) && (vcnt == '0);
  end

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      pix_x   <= '0;
      pix_y   <= '0;
      pix_req <= 1'b0;
    end else begin
      pix_x   <= hcnt;
      pix_y   <= vcnt;
      pix_req <= st0.act;
    end
  end

  // One stage matches the pix_req register, PIPE_LAT more cover the fetch latency.
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      for (int i = 0; i <= PIPE_LAT; i++) dly[i] <= '0;
    end else begin
      dly[0] <= st0;
      for (int i = 1; i <= PIPE_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  assign last = dly[PIPE_LAT];

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      red_p       <= '0;
      green_p     <= '0;
      blue_p      <= '0;
      blank       <= 1'b1;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      frame_start <= 1'b0;
    end else begin
      // Fetch data is only trusted when its own request was issued.
      red_p       <= last.act ? pix_rgb_in[23:16] : 8'h00;
      green_p     <= last.act ? pix_rgb_in[15:8]  : 8'h00;
      blue_p      <= last.act ? pix_rgb_in[7:0]   : 8'h00;
      blank       <= ~last.act;
      hsync       <= ~(last.hs ^ HS_POL);
      vsync       <= ~(last.vs ^ VS_POL);
      frame_start <= last.fs;
    end
  end

endmodule

// File: tb/tb_dvid_timing_gen.sv
// Bench for dvid_timing_gen: three instances (full VGA raster, and two small rasters with other latencies and polarities).
module tb_dvid_timing_gen;

  localparam int N = 3;
  localparam int LAT [N] = '{2, 1, 5};
  localparam int HA  [N] = '{640, 16, 16};
  localparam int HFP [N] = '{16, 2, 2};
  localparam int HSW [N] = '{96, 4, 4};
  localparam int HBP [N] = '{48, 3, 3};
  localparam int VA  [N] = '{480, 6, 6};
  localparam int VFP [N] = '{10, 1, 1};
  localparam int VSW [N] = '{2, 2, 2};
  localparam int VBP [N] = '{33, 2, 2};
  localparam bit POL [N] = '{1'b0, 1'b1, 1'b1};

  logic        clk;
  logic        rst_n   [N];
  logic [10:0] px      [N];
  logic [10:0] py      [N];
  logic        req     [N];
  logic [23:0] rgb_in  [N];
  logic [7:0]  red_o   [N];
  logic [7:0]  grn_o   [N];
  logic [7:0]  blu_o   [N];
  logic        blank_o [N];
  logic        hs_o    [N];
  logic        vs_o    [N];
  logic        fs_o    [N];

  int vectors = 0;
  int miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int L = LAT[gi];
    logic [23:0] dl [8];

    dvid_timing_gen #(
      .H_ACTIVE(HA[gi]), .H_FP(HFP[gi]), .H_SYNC(HSW[gi]), .H_BP(HBP[gi]),
      .V_ACTIVE(VA[gi]), .V_FP(VFP[gi]), .V_SYNC(VSW[gi]), .V_BP(VBP[gi]),
      .HS_POL(POL[gi]), .VS_POL(POL[gi]), .PIPE_LAT(L), .CW(11)
    ) u_dut (
      .clk_pixel  (clk),
      .reset_n    (rst_n[gi]),
      .pix_x      (px[gi]),
      .pix_y      (py[gi]),
      .pix_req    (req[gi]),
      .pix_rgb_in (rgb_in[gi]),
      .red_p      (red_o[gi]),
      .green_p    (grn_o[gi]),
      .blue_p     (blu_o[gi]),
      .blank      (blank_o[gi]),
      .hsync      (hs_o[gi]),
      .vsync      (vs_o[gi]),
      .frame_start(fs_o[gi])
    );

    // Game-logic stand-in: answers each request PIPE_LAT cycles later; all-ones when no request.
    always @(posedge clk) begin
      dl[0] <= req[gi] ? {px[gi][7:0], py[gi][7:0], 8'h5A} : 24'hFFFFFF;
      for (int k = 1; k < 8; k++) dl[k] <= dl[k-1];
    end
    assign rgb_in[gi] = dl[L-1];
  end

  function automatic logic [27:0] rst_tuple(int g);
    return {24'h000000, 1'b1, ~POL[g], ~POL[g], 1'b0};
  endfunction

  // Reference raster per instance; expected dvid tuples wait in a queue for PIPE_LAT+1 cycles.
  task automatic scoreboard();
    logic        smp [N];
    bit          run [N];
    int          fx  [N];
    int          fy  [N];
    logic [27:0] q   [N][$];
    logic [27:0] e;
    logic [27:0] o;
    bit          a, hsa, vsa;
    int          ht, vt;
    forever begin
      @(posedge clk);
      for (int g = 0; g < N; g++) smp[g] = rst_n[g];
      @(negedge clk);
      for (int g = 0; g < N; g++) begin
        o = {red_o[g], grn_o[g], blu_o[g], blank_o[g], hs_o[g], vs_o[g], fs_o[g]};
        if (smp[g] === 1'b0) begin
          run[g] = 0;
          q[g].delete();
          vectors++;
          if ({px[g], py[g], req[g], o} !== {11'd0, 11'd0, 1'b0, rst_tuple(g)}) begin
            miscompares++;
            $display("FAIL sb%0d reset_state: got x=%0d y=%0d req=%b out=%h, want 0 0 0 %h",
                     g, px[g], py[g], req[g], o, rst_tuple(g));
          end
        end else if (smp[g] === 1'b1) begin
          if (!run[g]) begin
            run[g] = 1;
            fx[g]  = 0;
            fy[g]  = 0;
            for (int k = 0; k < LAT[g] + 1; k++) q[g].push_back(rst_tuple(g));
          end
          ht  = HA[g] + HFP[g] + HSW[g] + HBP[g];
          vt  = VA[g] + VFP[g] + VSW[g] + VBP[g];
          a   = (fx[g] < HA[g]) && (fy[g] < VA[g]);
          hsa = (fx[g] >= HA[g] + HFP[g]) && (fx[g] < HA[g] + HFP[g] + HSW[g]);
          vsa = (fy[g] >= VA[g] + VFP[g]) && (fy[g] < VA[g] + VFP[g] + VSW[g]);
          vectors++;
          if ({px[g], py[g], req[g]} !== {11'(fx[g]), 11'(fy[g]), a}) begin
            miscompares++;
            $display("FAIL sb%0d fetch: got x=%0d y=%0d req=%b, want x=%0d y=%0d req=%b",
                     g, px[g], py[g], req[g], fx[g], fy[g], a);
          end
          e = {(a ? {fx[g][7:0], fy[g][7:0], 8'h5A} : 24'h000000), ~a,
               (hsa ? POL[g] : ~POL[g]), (vsa ? POL[g] : ~POL[g]),
               (fx[g] == 0 && fy[g] == 0)};
          q[g].push_back(e);
          e = q[g].pop_front();
          vectors++;
          if (o !== e) begin
            miscompares++;
            $display("FAIL sb%0d dvid_out: got {rgb,blank,hs,vs,fs}=%h, want %h", g, o, e);
          end
          fx[g]++;
          if (fx[g] == ht) begin
            fx[g] = 0;
            fy[g]++;
            if (fy[g] == vt) fy[g] = 0;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    int fb [N];
    int ff [N];
    for (int g = 0; g < N; g++) begin fb[g] = -1; ff[g] = -1; end
    repeat (3) @(negedge clk);
    for (int g = 0; g < N; g++) begin
      vectors++;
      if ({blank_o[g], hs_o[g], vs_o[g], fs_o[g], req[g]} !== {1'b1, ~POL[g], ~POL[g], 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_hold%0d: got blank=%b hs=%b vs=%b fs=%b req=%b", g,
                 blank_o[g], hs_o[g], vs_o[g], fs_o[g], req[g]);
      end
    end
    for (int g = 0; g < N; g++) rst_n[g] = 1'b1;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      for (int g = 0; g < N; g++) begin
        if (n == 0) begin
          vectors++;
          if ({req[g], px[g], py[g]} !== {1'b1, 11'd0, 11'd0}) begin
            miscompares++;
            $display("FAIL first_req%0d: got req=%b x=%0d y=%0d, want 1 0 0", g, req[g], px[g], py[g]);
          end
        end
        if (fb[g] < 0 && blank_o[g] === 1'b0) fb[g] = n;
        if (ff[g] < 0 && fs_o[g] === 1'b1) ff[g] = n;
      end
    end
    for (int g = 0; g < N; g++) begin
      vectors++;
      if (fb[g] !== LAT[g] + 1 || ff[g] !== LAT[g] + 1) begin
        miscompares++;
        $display("FAIL first_pixel%0d: blank fell at %0d, frame_start at %0d, want both %0d",
                 g, fb[g], ff[g], LAT[g] + 1);
      end
    end
  endtask

  task automatic test_line();
    logic prev;
    bit   found;
    int   nlo, first_hi, first_hs, nhs;
    found = 0;
    prev  = blank_o[0];
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (prev === 1'b1 && blank_o[0] === 1'b0) begin found = 1; break; end
      prev = blank_o[0];
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL line_start: got no blank falling edge in 2000 cycles, want one");
      return;
    end
    nlo = 0; first_hi = -1; first_hs = -1; nhs = 0;
    for (int i = 0; i < 800; i++) begin
      if (i > 0) @(negedge clk);
      if (blank_o[0] === 1'b0) nlo++;
      else if (first_hi < 0) first_hi = i;
      if (hs_o[0] === POL[0]) begin
        nhs++;
        if (first_hs < 0) first_hs = i;
      end
    end
    vectors++;
    if (nlo !== 640 || first_hi !== 640) begin
      miscompares++;
      $display("FAIL line_blank: got low=%0d high_from=%0d, want 640 640", nlo, first_hi);
    end
    vectors++;
    if (first_hs !== 656 || nhs !== 96) begin
      miscompares++;
      $display("FAIL line_hsync: got start=%0d width=%0d, want 656 96", first_hs, nhs);
    end
    @(negedge clk);
    vectors++;
    if (blank_o[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL line_period: got blank=%b at pixel 800, want 0", blank_o[0]);
    end
  endtask

  task automatic test_frames();
    for (int g = 1; g < N; g++) begin
      int ht, vt, per, vfirst, vlen;
      bit seen;
      ht   = HA[g] + HFP[g] + HSW[g] + HBP[g];
      vt   = VA[g] + VFP[g] + VSW[g] + VBP[g];
      seen = 0;
      for (int k = 0; k < 2 * ht * vt; k++) begin
        @(negedge clk);
        if (fs_o[g] === 1'b1) begin seen = 1; break; end
      end
      if (!seen) begin
        vectors++;
        miscompares++;
        $display("FAIL frame_wait%0d: got no frame_start, want one within %0d cycles", g, 2 * ht * vt);
        continue;
      end
      for (int f = 0; f < 2; f++) begin
        per = -1; vfirst = -1; vlen = 0;
        for (int i = 0; i < 2 * ht * vt; i++) begin
          if (i > 0) begin
            @(negedge clk);
            if (fs_o[g] === 1'b1) begin per = i; break; end
          end
          if (vs_o[g] === POL[g]) begin
            vlen++;
            if (vfirst < 0) vfirst = i;
          end
        end
        vectors++;
        if (per !== ht * vt) begin
          miscompares++;
          $display("FAIL frame_period%0d: got %0d, want %0d", g, per, ht * vt);
        end
        vectors++;
        if (vfirst !== (VA[g] + VFP[g]) * ht || vlen !== VSW[g] * ht) begin
          miscompares++;
          $display("FAIL frame_vsync%0d: got start=%0d width=%0d, want %0d %0d",
                   g, vfirst, vlen, (VA[g] + VFP[g]) * ht, VSW[g] * ht);
        end
      end
    end
  endtask

  task automatic test_midframe_reset(input int g, input int x, input int y);
    bit hit;
    hit = 0;
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      if (px[g] === 11'(x) && py[g] === 11'(y)) begin hit = 1; break; end
    end
    if (!hit) begin
      vectors++;
      miscompares++;
      $display("FAIL midreset_wait%0d: got no fetch at (%0d,%0d), want one", g, x, y);
      return;
    end
    rst_n[g] = 1'b0;
    @(negedge clk);
    vectors++;
    if ({blank_o[g], red_o[g], grn_o[g], blu_o[g], hs_o[g], vs_o[g], fs_o[g], req[g]} !==
        {1'b1, 24'h000000, ~POL[g], ~POL[g], 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL midreset_out%0d: got blank=%b rgb=%h hs=%b vs=%b fs=%b req=%b, want 1 0 %b %b 0 0",
               g, blank_o[g], {red_o[g], grn_o[g], blu_o[g]}, hs_o[g], vs_o[g], fs_o[g], req[g],
               ~POL[g], ~POL[g]);
    end
    repeat (2) @(negedge clk);
    rst_n[g] = 1'b1;
    @(negedge clk);
    vectors++;
    if ({px[g], py[g], req[g]} !== {11'd0, 11'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL midreset_restart%0d: got x=%0d y=%0d req=%b, want 0 0 1", g, px[g], py[g], req[g]);
    end
    repeat (LAT[g] + 1) @(negedge clk);
    vectors++;
    if (fs_o[g] !== 1'b1 || blank_o[g] !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_frame%0d: got fs=%b blank=%b, want 1 0", g, fs_o[g], blank_o[g]);
    end
  endtask

  initial begin
    for (int g = 0; g < N; g++) rst_n[g] = 1'b0;
    fork
      scoreboard();
    join_none
    test_reset();
    test_line();
    test_midframe_reset(0, 300, 4);
    test_frames();
    test_midframe_reset(1, 10, 4);
    test_midframe_reset(2, 10, 4);
    repeat (600) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
